// File: rtl/a51_multi_step_if.sv
// Handshake bundle for the A5/1 multi-step clocking engine.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : engine side (drives in_ready, out_*)
// Signals:
//   in_valid/in_ready   input transaction handshake
//   in_mode             0 = majority clocking, 1 = clock all registers
//   in_state[63:0]      R1=[63:45], R2=[44:23], R3=[22:0]
//   out_valid/out_ready output transaction handshake
//   out_state[63:0]     advanced state, same packing
//   out_keystream       one bit per step, only when A51_KEYSTREAM_EN is defined
// Optional feature macro: A51_KEYSTREAM_EN (adds KS_BITS parameter and out_keystream).
interface a51_multi_step_if
`ifdef A51_KEYSTREAM_EN
    #(parameter int unsigned KS_BITS = 1)
`endif
    ();
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_state;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;
`ifdef A51_KEYSTREAM_EN
    logic [KS_BITS-1:0] out_keystream;

    modport master (
        output in_valid, in_mode, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_keystream
    );
    modport slave (
        input  in_valid, in_mode, in_state, out_ready,
        output in_ready, out_valid, out_state, out_keystream
    );
`else
    modport master (
        output in_valid, in_mode, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );
    modport slave (
        input  in_valid, in_mode, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
`endif
endinterface

// File: rtl/a51_multi_step.sv
// Pipelined A5/1 clocking engine. Each transaction is advanced
// STEPS_PER_STAGE*STAGES A5/1 steps, STEPS_PER_STAGE of them unrolled inside each
// of STAGES register stages, with valid/ready flow control and bubble compression.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, has priority over enable
//   enable  global clock enable; low freezes the whole pipeline and drops in_ready
//   bus     a51_multi_step_if.slave: in_valid/in_ready/in_mode/in_state,
//           out_valid/out_ready/out_state[/out_keystream]
// Optional feature macro: A51_KEYSTREAM_EN builds per-stage keystream accumulators
// and drives out_keystream (bit i = output of step i+1). The state path and latency
// are identical either way.
module a51_multi_step #(
    parameter int unsigned STEPS_PER_STAGE = 1,
    parameter int unsigned STAGES          = 1
) (
    input logic             clk,
    input logic             rst,
    input logic             enable,
    a51_multi_step_if.slave bus
);

`ifdef A51_KEYSTREAM_EN
    localparam int unsigned N = STEPS_PER_STAGE * STAGES;
`endif

    // One A5/1 step; mode 1 clocks all registers, mode 0 uses majority clocking.
    function automatic logic [63:0] a51_step(input logic [63:0] st, input logic mode);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic        maj;
        r1  = st[63:45];
        r2  = st[44:23];
        r3  = st[22:0];
        maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        if (mode || (r1[8] == maj)) r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
        if (mode || (r2[10] == maj)) r2 = {r2[20:0], r2[21] ^ r2[20]};
        if (mode || (r3[10] == maj)) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
        return {r1, r2, r3};
    endfunction

    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] adv;

    // A stage may advance unless it and every stage after it is full and the consumer
    // is stalling; this is the unrolled form of the per-stage advance chain.
    always_comb begin
        adv = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            adv[s] = enable &
                     (bus.out_ready | ~(&(valid_vec | ((STAGES'(1) << s) - STAGES'(1)))));
        end
    end

    assign bus.in_ready = adv[0] & ~rst;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic        src_valid;
        logic        src_mode;
        logic [63:0] src_state;
        logic        valid_q;
        logic        mode_q;
        logic [63:0] state_q;
        logic [63:0] state_d;
`ifdef A51_KEYSTREAM_EN
        logic [N-1:0] src_ks;
        logic [N-1:0] ks_q;
        logic [N-1:0] ks_d;
`endif

        if (s == 0) begin : g_src_in
            assign src_valid = bus.in_valid;
            assign src_mode  = bus.in_mode;
            assign src_state = bus.in_state;
`ifdef A51_KEYSTREAM_EN
            assign src_ks    = '0;
`endif
        end else begin : g_src_prev
            assign src_valid = g_stage[s-1].valid_q;
            assign src_mode  = g_stage[s-1].mode_q;
            assign src_state = g_stage[s-1].state_q;
`ifdef A51_KEYSTREAM_EN
            assign src_ks    = g_stage[s-1].ks_q;
`endif
        end

        always_comb begin
            state_d = src_state;
`ifdef A51_KEYSTREAM_EN
            ks_d    = src_ks;
`endif
            for (int unsigned j = 0; j < STEPS_PER_STAGE; j++) begin
                state_d = a51_step(state_d, src_mode);
`ifdef A51_KEYSTREAM_EN
                // Output bit is taken after the shift.
                ks_d[s * STEPS_PER_STAGE + j] = state_d[63] ^ state_d[44] ^ state_d[22];
`endif
            end
        end

        // Payload only loads with a valid transaction, so a drained pipe keeps its
        // last data and bubbles never overwrite anything visible.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                mode_q  <= 1'b0;
                state_q <= '0;
`ifdef A51_KEYSTREAM_EN
                ks_q    <= '0;
`endif
            end else if (adv[s]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    mode_q  <= src_mode;
                    state_q <= state_d;
`ifdef A51_KEYSTREAM_EN
                    ks_q    <= ks_d;
`endif
                end
            end
        end

        assign valid_vec[s] = valid_q;
    end

    assign bus.out_valid     = g_stage[STAGES-1].valid_q;
    assign bus.out_state     = g_stage[STAGES-1].state_q;
`ifdef A51_KEYSTREAM_EN
    assign bus.out_keystream = g_stage[STAGES-1].ks_q;
`endif

endmodule

// File: tb/tb_a51_multi_step.sv
// Bench for a51_multi_step: a 1x1 instance for known vectors and a 2x3 instance
// driven with random traffic, checked by a scoreboard against a software A5/1 model.
module tb_a51_multi_step;

    localparam int unsigned N1 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, en0, rst1, en1;

`ifdef A51_KEYSTREAM_EN
    a51_multi_step_if #(.KS_BITS(1))  b0 ();
    a51_multi_step_if #(.KS_BITS(N1)) b1 ();
`else
    a51_multi_step_if b0 ();
    a51_multi_step_if b1 ();
`endif

    a51_multi_step #(.STEPS_PER_STAGE(1), .STAGES(1)) dut0 (
        .clk(clk), .rst(rst0), .enable(en0), .bus(b0)
    );
    a51_multi_step #(.STEPS_PER_STAGE(2), .STAGES(3)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1), .bus(b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Software A5/1: three registers as integers, majority by counting ones.
    function automatic void ref_model(input logic [63:0] st, input logic mode, input int n,
                                      output logic [63:0] st_o, output logic [63:0] ks_o);
        longint unsigned r1, r2, r3;
        int ones;
        bit maj, f1, f2, f3;
        r1 = longint'(st[63:45]);
        r2 = longint'(st[44:23]);
        r3 = longint'(st[22:0]);
        ks_o = '0;
        for (int i = 0; i < n; i++) begin
            ones = int'(r1[8]) + int'(r2[10]) + int'(r3[10]);
            maj  = (ones >= 2);
            f1 = r1[18] ^ r1[17] ^ r1[16] ^ r1[13];
            f2 = r2[21] ^ r2[20];
            f3 = r3[22] ^ r3[21] ^ r3[20] ^ r3[7];
            if (mode || r1[8] == maj)  r1 = ((r1 << 1) | 64'(f1)) & 64'h7FFFF;
            if (mode || r2[10] == maj) r2 = ((r2 << 1) | 64'(f2)) & 64'h3FFFFF;
            if (mode || r3[10] == maj) r3 = ((r3 << 1) | 64'(f3)) & 64'h7FFFFF;
            ks_o[i] = r1[18] ^ r2[21] ^ r3[22];
        end
        st_o = {r1[18:0], r2[21:0], r3[22:0]};
    endfunction

    typedef struct {
        logic [63:0] st;
        logic [63:0] ks;
    } exp_t;
    exp_t sb[$];

    // Monitor for dut1: samples 1 time unit before each rising edge.
    logic        hold_pend = 1'b0;
    logic [63:0] hold_st;
    logic [63:0] hold_ks;
    logic        pop;
    exp_t        e;

    always @(negedge clk) begin
        #4;
        if (rst1) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(b1.out_valid), 64'd1);
                check("hold_state", b1.out_state, hold_st);
`ifdef A51_KEYSTREAM_EN
                check("hold_ks", 64'(b1.out_keystream), hold_ks);
`endif
            end
            pop = b1.out_valid & b1.out_ready & en1;
            if (pop) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stale_output: got %h expected no output", b1.out_state);
                end else begin
                    e = sb.pop_front();
                    check("sb_state", b1.out_state, e.st);
`ifdef A51_KEYSTREAM_EN
                    check("sb_ks", 64'(b1.out_keystream), 64'(e.ks[N1-1:0]));
`endif
                end
            end
            hold_pend = b1.out_valid & ~pop;
            hold_st   = b1.out_state;
`ifdef A51_KEYSTREAM_EN
            hold_ks   = 64'(b1.out_keystream);
`endif
            if (b1.in_valid && b1.in_ready) begin
                ref_model(b1.in_state, b1.in_mode, int'(N1), e.st, e.ks);
                sb.push_back(e);
            end
            if (!en1) check("frozen_in_ready", 64'(b1.in_ready), 64'd0);
        end
    end

    task automatic run0(input string name, input logic [63:0] st, input logic mode,
                        input logic [63:0] exp_st, input logic exp_ks);
        int cyc;
        @(negedge clk);
        b0.in_valid = 1'b1;
        b0.in_state = st;
        b0.in_mode  = mode;
        @(negedge clk);
        b0.in_valid = 1'b0;
        cyc = 0;
        while (!b0.out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_valid"}, 64'(b0.out_valid), 64'd1);
        check(name, b0.out_state, exp_st);
`ifdef A51_KEYSTREAM_EN
        check({name, "_ks"}, 64'(b0.out_keystream), 64'(exp_ks));
`else
        if (exp_ks) begin end
`endif
    endtask

    task automatic push1(input logic [63:0] st, input logic mode, input logic exp_ready,
                         input string name);
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in_state = st;
        b1.in_mode  = mode;
        #4;
        check(name, 64'(b1.in_ready), 64'(exp_ready));
    endtask

    task automatic drain1();
        int c = 0;
        b1.in_valid = 1'b0;
        en1 = 1'b1;
        b1.out_ready = 1'b1;
        while ((sb.size() != 0 || b1.out_valid) && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d outstanding, expected 0", sb.size());
        end
    endtask

    logic [63:0] rs, ms, mk;
    logic        rm;

    initial begin
        rst0 = 1'b1; en0 = 1'b1;
        rst1 = 1'b1; en1 = 1'b1;
        b0.in_valid = 1'b0; b0.in_mode = 1'b0; b0.in_state = '0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_mode = 1'b0; b1.in_state = '0; b1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst0_valid", 64'(b0.out_valid), 64'd0);
        check("rst0_state", b0.out_state, 64'd0);
        check("rst0_in_ready", 64'(b0.in_ready), 64'd0);
        check("rst1_valid", 64'(b1.out_valid), 64'd0);
        check("rst1_state", b1.out_state, 64'd0);
        check("rst1_in_ready", 64'(b1.in_ready), 64'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("post_rst0_ready", 64'(b0.in_ready), 64'd1);
        check("post_rst1_ready", 64'(b1.in_ready), 64'd1);

        // Known single-step vectors.
        run0("vec_r3", 64'h0000_0000_0000_0001, 1'b1, 64'h0000_0000_0000_0002, 1'b0);
        run0("vec_r1fb", 64'h8000_0000_0000_0000, 1'b1, 64'h0000_2000_0000_0000, 1'b0);
        run0("vec_maj", 64'h0020_0002_0000_0001, 1'b0, 64'h0040_0004_0000_0001, 1'b0);
        run0("vec_zero0", 64'd0, 1'b0, 64'd0, 1'b0);
        run0("vec_zero1", 64'd0, 1'b1, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rs = {$urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            ref_model(rs, rm, 1, ms, mk);
            run0("vec_rand", rs, rm, ms, mk[0]);
        end

        // Fill with consumer stalled: three accepted, fourth held off.
        for (int k = 0; k < 3; k++) push1({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                                          1'b1, "fill_ready");
        push1({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, "full_ready");
        repeat (3) begin
            @(negedge clk);
            #4;
            check("full_ready_hold", 64'(b1.in_ready), 64'd0);
        end
        @(negedge clk);
        b1.out_ready = 1'b1;
        #4;
        check("pop_push_ready", 64'(b1.in_ready), 64'd1);
        @(negedge clk);
        b1.in_valid = 1'b0;
        drain1();

        // All-zero state through the long pipe in both modes.
        push1(64'd0, 1'b0, 1'b1, "zero_ready");
        push1(64'd0, 1'b1, 1'b1, "zero_ready");
        drain1();

        // Random traffic with random enable and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            b1.in_valid  = ($urandom_range(0, 3) != 0);
            b1.in_mode   = 1'($urandom_range(0, 1));
            b1.in_state  = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            en1          = ($urandom_range(0, 7) != 0);
            b1.out_ready = en1 && ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        drain1();

        // Reset with three in flight; enable low during reset too.
        for (int k = 0; k < 3; k++) push1({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                                          1'b1, "pre_rst_ready");
        @(negedge clk);
        b1.in_valid = 1'b0;
        rst1 = 1'b1;
        en1  = 1'b0;
        #4;
        check("rst_in_ready", 64'(b1.in_ready), 64'd0);
        @(negedge clk);
        check("mid_rst_valid", 64'(b1.out_valid), 64'd0);
        check("mid_rst_state", b1.out_state, 64'd0);
        rst1 = 1'b0;
        en1  = 1'b1;
        #4;
        check("after_rst_ready", 64'(b1.in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_stale_valid", 64'(b1.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
